// File: rtl/pipeline_stall_sequencer.sv
// Hazard/stall sequencer for a 5-stage pipeline: load-use and branch-operand stalls,
// branch/jump flushes, and a full freeze while the data memory is busy. The freeze has a timeout.
module pipeline_stall_sequencer #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ID_EX_mem_read,
  input  logic             ID_EX_reg_write,
  input  logic [4:0]       ID_EX_rt,
  input  logic [4:0]       ID_EX_rd,
  input  logic             EX_MEM_mem_read,
  input  logic [4:0]       EX_MEM_rd,
  input  logic [4:0]       IF_ID_rs,
  input  logic [4:0]       IF_ID_rt,
  input  logic             branch,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             mem_busy,
  input  logic             cnt_clr,
  output logic             pc_stall,
  output logic             IF_ID_stall,
  output logic             ID_EX_bubble,
  output logic             IF_ID_flush,
  output logic             ID_EX_stall,
  output logic             EX_MEM_stall,
  output logic             MEM_WB_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_FREEZE  = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [9:0]       busy_cnt_q, busy_cnt_d;
  logic [10:0]      busy_inc;
  logic             set_timeout;
  logic             mem_timeout_q;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             load_use, br_alu, br_load, hazard;

  // Register 0 is hard-wired zero, so it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
    return (a != 5'd0) && (a == b);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign load_use = ID_EX_mem_read &&
                    (reg_match(ID_EX_rt, IF_ID_rs) || reg_match(ID_EX_rt, IF_ID_rt));
  assign br_alu   = branch && ID_EX_reg_write &&
                    (reg_match(ID_EX_rd, IF_ID_rs) || reg_match(ID_EX_rd, IF_ID_rt));
  assign br_load  = branch && EX_MEM_mem_read &&
                    (reg_match(EX_MEM_rd, IF_ID_rs) || reg_match(EX_MEM_rd, IF_ID_rt));
  assign hazard   = load_use || br_alu || br_load;
  assign busy_inc = {1'b0, busy_cnt_q} + 11'd1;

  // Mealy control: a cycle with mem_busy low is always judged by RUN rules,
  // which is what makes the release cycle of a freeze behave like RUN.
  always_comb begin
    pc_stall      = 1'b0;
    IF_ID_stall   = 1'b0;
    ID_EX_bubble  = 1'b0;
    IF_ID_flush   = 1'b0;
    ID_EX_stall   = 1'b0;
    EX_MEM_stall  = 1'b0;
    MEM_WB_bubble = 1'b0;
    if (rst_n) begin
      if (mem_busy) begin
        pc_stall      = 1'b1;
        IF_ID_stall   = 1'b1;
        ID_EX_stall   = 1'b1;
        EX_MEM_stall  = 1'b1;
        MEM_WB_bubble = 1'b1;
      end else if (hazard) begin
        pc_stall     = 1'b1;
        IF_ID_stall  = 1'b1;
        ID_EX_bubble = 1'b1;
      end else if (branch_taken || jump) begin
        IF_ID_flush = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    busy_cnt_d  = '0;
    set_timeout = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mem_busy) state_d = ST_FREEZE;
      end
      ST_FREEZE: begin
        if (!mem_busy) begin
          state_d = ST_RUN;
        end else if (busy_inc >= 11'(TIMEOUT)) begin
          state_d     = ST_TIMEOUT;
          set_timeout = 1'b1;
        end else begin
          busy_cnt_d = busy_inc[9:0];
        end
      end
      ST_TIMEOUT: begin
        if (!mem_busy) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      busy_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  // cnt_clr wins over a same-cycle increment or timeout set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      mem_timeout_q <= 1'b0;
    end else if (cnt_clr) begin
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      if (pc_stall)    stall_cnt_q <= sat_inc(stall_cnt_q);
      if (IF_ID_flush) flush_cnt_q <= sat_inc(flush_cnt_q);
      if (set_timeout) mem_timeout_q <= 1'b1;
    end
  end

  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;
  assign mem_timeout = mem_timeout_q;
  assign state       = state_q;

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// Directed bench for pipeline_stall_sequencer: single-cycle vector table plus
// hand sequences for freeze, timeout, counter saturation/clear and async reset.
module tb_pipeline_stall_sequencer;

  localparam int TMO = 4;
  localparam int CW  = 4;

  // Control output group order: pc, IF_ID_stall, ID_EX_bubble, flush, ID_EX_stall, EX_MEM_stall, MEM_WB_bubble
  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] HAZ  = 7'b1110000;
  localparam logic [6:0] FLU  = 7'b0001000;
  localparam logic [6:0] FRZ  = 7'b1100111;

  logic          clk, rst_n;
  logic          ID_EX_mem_read, ID_EX_reg_write, EX_MEM_mem_read;
  logic [4:0]    ID_EX_rt, ID_EX_rd, EX_MEM_rd, IF_ID_rs, IF_ID_rt;
  logic          branch, branch_taken, jump, mem_busy, cnt_clr;
  logic          pc_stall, IF_ID_stall, ID_EX_bubble, IF_ID_flush;
  logic          ID_EX_stall, EX_MEM_stall, MEM_WB_bubble, mem_timeout;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [1:0]    state;

  int n_checks = 0;
  int n_errors = 0;

  pipeline_stall_sequencer #(.TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ID_EX_mem_read(ID_EX_mem_read), .ID_EX_reg_write(ID_EX_reg_write),
    .ID_EX_rt(ID_EX_rt), .ID_EX_rd(ID_EX_rd),
    .EX_MEM_mem_read(EX_MEM_mem_read), .EX_MEM_rd(EX_MEM_rd),
    .IF_ID_rs(IF_ID_rs), .IF_ID_rt(IF_ID_rt),
    .branch(branch), .branch_taken(branch_taken), .jump(jump),
    .mem_busy(mem_busy), .cnt_clr(cnt_clr),
    .pc_stall(pc_stall), .IF_ID_stall(IF_ID_stall), .ID_EX_bubble(ID_EX_bubble),
    .IF_ID_flush(IF_ID_flush), .ID_EX_stall(ID_EX_stall), .EX_MEM_stall(EX_MEM_stall),
    .MEM_WB_bubble(MEM_WB_bubble), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       id_ex_mem_read;
    logic       id_ex_reg_write;
    logic [4:0] id_ex_rt;
    logic [4:0] id_ex_rd;
    logic       ex_mem_mem_read;
    logic [4:0] ex_mem_rd;
    logic [4:0] if_id_rs;
    logic [4:0] if_id_rt;
    logic       br;
    logic       br_taken;
    logic       jmp;
    logic       busy;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [6:0] ctrl();
    return {pc_stall, IF_ID_stall, ID_EX_bubble, IF_ID_flush,
            ID_EX_stall, EX_MEM_stall, MEM_WB_bubble};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    ID_EX_mem_read  = v.id_ex_mem_read;
    ID_EX_reg_write = v.id_ex_reg_write;
    ID_EX_rt        = v.id_ex_rt;
    ID_EX_rd        = v.id_ex_rd;
    EX_MEM_mem_read = v.ex_mem_mem_read;
    EX_MEM_rd       = v.ex_mem_rd;
    IF_ID_rs        = v.if_id_rs;
    IF_ID_rt        = v.if_id_rt;
    branch          = v.br;
    branch_taken    = v.br_taken;
    jump            = v.jmp;
    mem_busy        = v.busy;
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 2 units later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic mr, input logic rw, input logic [4:0] rt,
                              input logic [4:0] rd, input logic emr, input logic [4:0] erd,
                              input logic [4:0] rs, input logic [4:0] irt, input logic b,
                              input logic bt, input logic j, input logic busy,
                              input logic [6:0] exp);
    vec_t v;
    v = '{mr, rw, rt, rd, emr, erd, rs, irt, b, bt, j, busy, exp};
    return v;
  endfunction

  function automatic int sat(input int v);
    return (v >= (1 << CW) - 1) ? (1 << CW) - 1 : v + 1;
  endfunction

  vec_t idle, lu8, v;
  int   exp_stall, exp_flush;

  initial begin
    //          mr rw rt  rd  emr erd rs  irt b  bt j  busy exp
    vecs[0]  = mk(0, 0, 0,  0,  0, 0,  0,  0,  0, 0, 0, 0, NONE);
    vecs[1]  = mk(1, 0, 8,  0,  0, 0,  8,  0,  0, 0, 0, 0, HAZ);
    vecs[2]  = mk(1, 0, 0,  0,  0, 0,  0,  0,  0, 0, 0, 0, NONE);
    vecs[3]  = mk(1, 0, 5,  0,  0, 0,  1,  5,  0, 0, 0, 0, HAZ);
    vecs[4]  = mk(0, 0, 5,  0,  0, 0,  5,  5,  0, 0, 0, 0, NONE);
    vecs[5]  = mk(0, 1, 0,  9,  0, 0,  0,  9,  1, 1, 0, 0, HAZ);
    vecs[6]  = mk(0, 1, 0,  3,  0, 0,  0,  9,  1, 1, 0, 0, FLU);
    vecs[7]  = mk(0, 0, 0,  0,  1, 12, 12, 0,  1, 0, 0, 0, HAZ);
    vecs[8]  = mk(0, 1, 0,  0,  1, 0,  0,  0,  1, 0, 0, 0, NONE);
    vecs[9]  = mk(0, 1, 0,  9,  0, 0,  9,  0,  0, 0, 0, 0, NONE);
    vecs[10] = mk(0, 0, 0,  0,  0, 0,  0,  0,  0, 0, 1, 0, FLU);
    vecs[11] = mk(1, 0, 7,  0,  0, 0,  7,  0,  0, 0, 1, 0, HAZ);
    vecs[12] = mk(1, 0, 7,  0,  0, 0,  7,  0,  0, 0, 1, 1, FRZ);
    vecs[13] = mk(0, 0, 0,  0,  0, 0,  0,  0,  0, 0, 1, 0, FLU);
    vecs[14] = mk(0, 0, 0,  0,  0, 0,  0,  0,  0, 0, 0, 1, FRZ);
    vecs[15] = mk(0, 0, 0,  0,  0, 0,  0,  0,  0, 0, 0, 0, NONE);
    idle = vecs[0];
    lu8  = vecs[1];

    // Reset: outputs forced low even with hazard/busy inputs present.
    cnt_clr = 1'b0;
    rst_n   = 1'b0;
    v = lu8;
    v.busy = 1'b1;
    apply(v);
    #2;
    check("reset_ctrl", 32'(ctrl()), 32'(NONE));
    tick();
    check("reset_ctrl_edge", 32'(ctrl()), 32'(NONE));
    check("reset_state", 32'(state), 0);
    check("reset_stall_cnt", 32'(stall_cnt), 0);
    check("reset_timeout", 32'(mem_timeout), 0);
    apply(idle);
    rst_n = 1'b1;
    tick();

    // Table of single-cycle vectors with a running counter model.
    exp_stall = 0;
    exp_flush = 0;
    for (int i = 0; i < 16; i++) begin
      apply(vecs[i]);
      #2;
      check($sformatf("vec%0d_ctrl", i), 32'(ctrl()), 32'(vecs[i].exp));
      tick();
      if (vecs[i].exp[6]) exp_stall = sat(exp_stall);
      if (vecs[i].exp[3]) exp_flush = sat(exp_flush);
    end
    check("table_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    check("table_flush_cnt", 32'(flush_cnt), 32'(exp_flush));
    check("table_state", 32'(state), 0);

    // Branch operand hazard holds the taken branch; it flushes once re-resolved.
    apply(idle);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    apply(vecs[5]);
    #2;
    check("br_alu_ctrl", 32'(ctrl()), 32'(HAZ));
    tick();
    apply(vecs[6]);
    #2;
    check("br_release_ctrl", 32'(ctrl()), 32'(FLU));
    tick();
    apply(idle);
    check("br_stall_cnt", 32'(stall_cnt), 1);
    check("br_flush_cnt", 32'(flush_cnt), 1);

    // Freeze dominates load-use for 3 cycles; the release cycle shows the stall.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    v = lu8;
    v.busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      apply(v);
      #2;
      check($sformatf("frz%0d_ctrl", i), 32'(ctrl()), 32'(FRZ));
      tick();
      check($sformatf("frz%0d_state", i), 32'(state), 1);
    end
    apply(lu8);
    #2;
    check("frz_release_ctrl", 32'(ctrl()), 32'(HAZ));
    tick();
    apply(idle);
    check("frz_release_state", 32'(state), 0);
    check("frz_stall_cnt", 32'(stall_cnt), 4);
    check("frz_timeout_clear", 32'(mem_timeout), 0);

    // Timeout after the TMO-th edge taken in FREEZE; sticky until cnt_clr.
    v = idle;
    v.busy = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      apply(v);
      #2;
      check($sformatf("tmo_c%0d_ctrl", i), 32'(ctrl()), 32'(FRZ));
      tick();
      check($sformatf("tmo_e%0d_state", i), 32'(state), (i >= TMO + 1) ? 2 : 1);
      check($sformatf("tmo_e%0d_flag", i), 32'(mem_timeout), (i >= TMO + 1) ? 1 : 0);
    end
    apply(idle);
    #2;
    check("tmo_release_ctrl", 32'(ctrl()), 32'(NONE));
    tick();
    check("tmo_back_to_run", 32'(state), 0);
    check("tmo_sticky", 32'(mem_timeout), 1);
    apply(lu8);
    cnt_clr = 1'b1;
    #2;
    check("clr_cycle_ctrl", 32'(ctrl()), 32'(HAZ));
    tick();
    cnt_clr = 1'b0;
    apply(idle);
    check("clr_timeout", 32'(mem_timeout), 0);
    check("clr_beats_inc", 32'(stall_cnt), 0);

    // Flush counter saturates at all-ones.
    apply(vecs[10]);
    for (int i = 0; i < 20; i++) tick();
    apply(idle);
    check("flush_cnt_sat", 32'(flush_cnt), (1 << CW) - 1);

    // Asynchronous reset in the middle of a freeze.
    v = lu8;
    v.busy = 1'b1;
    apply(v);
    tick();
    tick();
    check("pre_rst_state", 32'(state), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_ctrl", 32'(ctrl()), 32'(NONE));
    check("async_rst_state", 32'(state), 0);
    check("async_rst_stall_cnt", 32'(stall_cnt), 0);
    check("async_rst_flush_cnt", 32'(flush_cnt), 0);
    tick();
    apply(lu8);
    rst_n = 1'b1;
    #2;
    check("post_rst_ctrl", 32'(ctrl()), 32'(HAZ));
    tick();
    check("post_rst_state", 32'(state), 0);
    check("post_rst_stall_cnt", 32'(stall_cnt), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_sequencer.md
PIPELINE_STALL_SEQUENCER -- requirements
Module: pipeline_stall_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 255, max consecutive mem_busy cycles before error; legal range 1..1023.
REQ-002 Parameter CNT_W, default 16, width of performance counters.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 ID_EX_mem_read, ID_EX_reg_write  in  1 each  EX-stage instruction is a load / writes a register.
REQ-006 ID_EX_rt, ID_EX_rd  in  5 each  EX-stage load target / resolved write destination.
REQ-007 EX_MEM_mem_read  in  1; EX_MEM_rd  in  5  MEM-stage load and its destination.
REQ-008 IF_ID_rs, IF_ID_rt  in  5 each  ID-stage source registers.
REQ-009 branch, branch_taken, jump  in  1 each  ID-stage branch, its resolved outcome, ID-stage jump.
REQ-010 mem_busy  in  1  data memory needs another cycle.
REQ-011 cnt_clr  in  1  synchronous clear of counters and error.
REQ-012 pc_stall, IF_ID_stall, ID_EX_bubble, IF_ID_flush  out  1 each  hold PC, hold IF/ID, insert NOP into ID/EX, zero IF/ID.
REQ-013 ID_EX_stall, EX_MEM_stall, MEM_WB_bubble  out  1 each  full-freeze controls.
REQ-014 mem_timeout  out  1  sticky error flag.
REQ-015 stall_cnt, flush_cnt  out  CNT_W each  saturating performance counters.
REQ-016 state  out  2  FSM state: 0 RUN, 1 FREEZE, 2 TIMEOUT.

Function
REQ-017 Hazard terms SHALL be combinational; a register match SHALL ignore register 0.
REQ-018 load_use = ID_EX_mem_read and ID_EX_rt equals IF_ID_rs or IF_ID_rt.
REQ-019 br_alu = branch and ID_EX_reg_write and ID_EX_rd equals IF_ID_rs or IF_ID_rt.
REQ-020 br_load = branch and EX_MEM_mem_read and EX_MEM_rd equals IF_ID_rs or IF_ID_rt.
REQ-021 Priority SHALL be: mem_busy, then load_use, then br_alu/br_load, then flush.
REQ-022 Freeze (mem_busy=1, any state): pc_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_bubble = 1; ID_EX_bubble = 0; IF_ID_flush = 0.
REQ-023 Hazard stall (no freeze, load_use, br_alu or br_load): pc_stall, IF_ID_stall, ID_EX_bubble = 1; other outputs 0.
REQ-024 Flush (no freeze, no hazard, branch_taken or jump): IF_ID_flush = 1 for that cycle only; stall outputs 0.
REQ-025 Control outputs SHALL be Mealy: a decision takes effect in the same cycle as its inputs, with zero latency.
REQ-026 RUN -> FREEZE when mem_busy=1; FREEZE -> RUN when mem_busy=0; the release cycle is evaluated under RUN rules.
REQ-027 busy_cnt (internal) SHALL reset to 0 in RUN and increment each FREEZE cycle; when it reaches TIMEOUT with mem_busy=1, go to TIMEOUT and set mem_timeout.
REQ-028 TIMEOUT SHALL keep freeze outputs asserted while mem_busy=1, then return to RUN when mem_busy=0; mem_timeout stays set until cnt_clr or reset.
REQ-029 stall_cnt SHALL increment each cycle pc_stall=1; flush_cnt each cycle IF_ID_flush=1; both saturate at all-ones.
REQ-030 cnt_clr SHALL zero both counters and mem_timeout next edge, and take priority over an increment in the same cycle; FSM is unaffected.
REQ-031 branch_taken during a stall or freeze SHALL NOT flush; the held branch re-resolves once released.

Reset
REQ-032 rst_n=0 SHALL force state RUN, busy_cnt=0, counters 0, mem_timeout 0 immediately, with no clock edge required.
REQ-033 During reset, all control outputs SHALL be 0 regardless of inputs.
REQ-034 Reset mid-FREEZE SHALL abandon the freeze; the first cycle after rst_n rises is evaluated from RUN.

Verification
REQ-035 ID_EX_mem_read=1, ID_EX_rt=8, IF_ID_rs=8 for 1 cycle -> pc_stall=IF_ID_stall=ID_EX_bubble=1 that cycle, stall_cnt=1.
REQ-036 Same as REQ-035 with rt=0, rs=0 -> no stall, stall_cnt=0.
REQ-037 branch=1, branch_taken=1, ID_EX_reg_write=1, ID_EX_rd=9, IF_ID_rt=9 -> stall, no flush; next cycle rd=3 -> IF_ID_flush=1, flush_cnt=1.
REQ-038 mem_busy=1 for 3 cycles with load_use also true -> 3 freeze cycles, ID_EX_bubble=0, state FREEZE; release cycle shows the load_use stall.
REQ-039 TIMEOUT=4, mem_busy held 6 cycles -> state TIMEOUT and mem_timeout=1 after the 4th FREEZE edge; RUN after release; cnt_clr clears the flag.
REQ-040 rst_n pulsed low mid-FREEZE -> outputs 0 asynchronously, state=0, counters 0.
